audio_stream_sched: RTL

//  Paces and shares the stereo audio output path. Generates the 44.1 kHz sample strobe from the system clock

---
 rtl/audio_stream_sched_pkg.sv | 20 ++
 rtl/audio_stream_sched_fifo.sv | 64 ++++++
 rtl/audio_stream_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/audio_stream_sched_pkg.sv
// Shared definitions for the audio output scheduler: default audio format,
// the 44.1 kHz rate constant, the arbiter state encoding and a small sizing
// helper. Sample word layout is {left, right}, with left in the upper half.
// Each channel is unsigned offset PCM; mid-scale (silence) is 2^(AUDIO_BITS-1).
package audio_stream_sched_pkg;

    localparam int AUDIO_BITS_DEF = 12;
    localparam int SAMPLE_HZ_DEF  = 44100;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Width of an index into n sources; a single source still needs one bit.
    function automatic int src_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_stream_sched_fifo.sv
// audio_sample_fifo: small synchronous FIFO holding queued sample words.
// Push is ignored when full and pop is ignored when empty. Only the pointers
// and occupancy are cleared by aclr; the storage array is not reset.
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until pointed at by a valid entry.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/audio_stream_sched.sv
// audio_stream_sched: paces the stereo output at SAMPLE_HZ with a fractional
// accumulator, grants the output path round-robin to one of NUM_SRC producers,
// buffers the owner's samples and drives wreq/sample to the audio output.
// Build option: AUDIO_SCHED_SILENCE_ON_UNDERRUN_EN -- when defined an underrun
// emits mid-scale silence; otherwise the last emitted word is repeated.
module audio_stream_sched
    import audio_stream_sched_pkg::*;
#(
    parameter int AUDIO_BITS = AUDIO_BITS_DEF,
    parameter int NUM_SRC    = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int SAMPLE_HZ  = SAMPLE_HZ_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            aclr,
    input  logic                            enable,
    input  logic [NUM_SRC-1:0]              src_req,
    output logic [NUM_SRC-1:0]              src_grant,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*2*AUDIO_BITS-1:0] src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic                            wreq,
    output logic [2*AUDIO_BITS-1:0]         sample,
    output logic                            underrun
);

    localparam int SW    = 2 * AUDIO_BITS;
    localparam int OWN_W = src_idx_width(NUM_SRC);
    localparam int ACC_W = $clog2(CLK_HZ) + 1;

    localparam logic [AUDIO_BITS-1:0] MID      = AUDIO_BITS'(1) << (AUDIO_BITS - 1);
    localparam logic [SW-1:0]         MID_WORD = {MID, MID};
    localparam logic [ACC_W:0]        STEP_W   = (ACC_W+1)'(SAMPLE_HZ);
    localparam logic [ACC_W:0]        LIMIT_W  = (ACC_W+1)'(CLK_HZ);

    // Pacer
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             tick;

    // Arbiter
    arb_state_t       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] rr_q, rr_d;
    logic [OWN_W-1:0] hi_pick, lo_pick, pick;
    logic             hi_found, lo_found;

    // FIFO and output
    logic             push, pop;
    logic [SW-1:0]    push_data, head;
    logic             fifo_full, fifo_empty;
    logic             wreq_q, underrun_q;
    logic [SW-1:0]    sample_q, sample_d;

    assign acc_sum = {1'b0, acc_q} + STEP_W;

    // Fractional accumulator: one tick each time the running sum crosses CLK_HZ.
    always_comb begin
        acc_d = acc_q;
        tick  = 1'b0;
        if (!enable) begin
            acc_d = '0;
        end else if (acc_sum >= LIMIT_W) begin
            acc_d = ACC_W'(acc_sum - LIMIT_W);
            tick  = 1'b1;
        end else begin
            acc_d = acc_sum[ACC_W-1:0];
        end
    end

    // Round-robin pick: lowest requester at or above rr, else lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                lo_found = 1'b1;
                lo_pick  = OWN_W'(i);
                if (OWN_W'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_pick  = OWN_W'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    // Arbiter next state: the owner keeps the path until it drops its own request.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (lo_found) begin
                    state_d = ARB_OWNED;
                    owner_d = pick;
                end
            end
            ARB_OWNED: begin
                if (!src_req[owner_q]) begin
                    state_d = ARB_IDLE;
                    rr_d    = (owner_q == OWN_W'(NUM_SRC - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant decode, ready gating from the registered full flag, and owner data mux.
    always_comb begin
        src_grant = '0;
        push_data = '0;
        if (state_q == ARB_OWNED) src_grant[owner_q] = 1'b1;
        src_ready = src_grant & {NUM_SRC{~fifo_full}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (owner_q == OWN_W'(i)) push_data = src_data[i*SW +: SW];
        end
        push = |(src_valid & src_ready);
    end

    assign pop = tick & ~fifo_empty;

    // Word emitted on the next wreq; sample_q doubles as the last-emitted word.
    always_comb begin
        sample_d = sample_q;
        if (tick) begin
            if (!fifo_empty) begin
                sample_d = head;
            end else begin
`ifdef AUDIO_SCHED_SILENCE_ON_UNDERRUN_EN
                sample_d = MID_WORD;
`else
                sample_d = sample_q;
`endif
            end
        end
    end

    // Pacer, arbiter and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            acc_q      <= '0;
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            wreq_q     <= 1'b0;
            underrun_q <= 1'b0;
            sample_q   <= MID_WORD;
        end else begin
            acc_q      <= acc_d;
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            wreq_q     <= tick;
            underrun_q <= tick & fifo_empty;
            sample_q   <= sample_d;
        end
    end

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SW)
    ) u_fifo (
        .clk     (clk),
        .aclr    (aclr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_data),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wreq     = wreq_q;
    assign underrun = underrun_q;
    assign sample   = sample_q;

endmodule
